// File: rtl/seg7_scan_driver_if.sv
// Counter-to-display bundle: binary count and direction in, multiplexed
// 7-segment drive and converter status out.
interface seg7_scan_driver_if;
    logic [7:0]  value;
    logic        ud;
    logic        en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic [11:0] bcd;

    modport master (
        output value, ud, en,
        input  an, seg, dp, busy, bcd
    );

    modport slave (
        input  value, ud, en,
        output an, seg, dp, busy, bcd
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Binary->BCD (double-dabble, busy 10 clk per conversion) plus 4-digit active-low scan, SCAN_DIV clk per digit.
// No backpressure: value changes mid-conversion are picked up on return to IDLE. Optional SEG7_LZ_BLANK_EN blanks leading zeros.
module seg7_scan_driver #(
    parameter int SCAN_DIV = 50000
) (
    input logic                clk,
    input logic                reset,
    seg7_scan_driver_if.slave  bus
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t       state, state_nxt;
    logic         busy;
    logic         do_load;
    logic         do_shift;
    logic         do_done;

    logic [19:0]  sr;
    logic [19:0]  adj;
    logic [2:0]   shift_cnt;
    logic [7:0]   last_value;
    logic         force_conv;
    logic [11:0]  bcd_q;

    logic [PW-1:0] presc;
    logic          tick;
    logic [1:0]    idx;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic [6:0]    seg_nxt;
    logic          show_tens;
    logic          show_hund;

    // ---------------- converter FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (force_conv || (bus.value != last_value)) state_nxt = LOAD;
            LOAD:  state_nxt = SHIFT;
            SHIFT: if (shift_cnt == 3'd7) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        do_load  = (state == LOAD);
        do_shift = (state == SHIFT);
        do_done  = (state == DONE);
    end

    // Add-3 correction on the three BCD nibbles before each shift.
    always_comb begin
        adj = sr;
        if (sr[11:8]  >= 4'd5) adj[11:8]  = sr[11:8]  + 4'd3;
        if (sr[15:12] >= 4'd5) adj[15:12] = sr[15:12] + 4'd3;
        if (sr[19:16] >= 4'd5) adj[19:16] = sr[19:16] + 4'd3;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr         <= '0;
            shift_cnt  <= '0;
            last_value <= '0;
            force_conv <= 1'b1;
            bcd_q      <= '0;
        end else begin
            if (do_load) begin
                sr         <= {12'b0, bus.value};
                last_value <= bus.value;
                force_conv <= 1'b0;
                shift_cnt  <= '0;
            end
            if (do_shift) begin
                sr        <= adj << 1;
                shift_cnt <= shift_cnt + 3'd1;
            end
            if (do_done) begin
                bcd_q <= sr[19:8];
            end
        end
    end

    // ---------------- scan timing ----------------
    assign tick = (presc == PMAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            if (tick) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // ---------------- digit decode ----------------
    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

`ifdef SEG7_LZ_BLANK_EN
    assign show_hund = (bcd_q[11:8] != 4'd0);
    assign show_tens = (bcd_q[11:8] != 4'd0) || (bcd_q[7:4] != 4'd0);
`else
    assign show_hund = 1'b1;
    assign show_tens = 1'b1;
`endif

    always_comb begin
        seg_nxt = 7'b1111111;
        unique case (idx)
            2'd0: seg_nxt = digit_seg(bcd_q[3:0]);
            2'd1: seg_nxt = show_tens ? digit_seg(bcd_q[7:4])  : 7'b1111111;
            2'd2: seg_nxt = show_hund ? digit_seg(bcd_q[11:8]) : 7'b1111111;
            2'd3: seg_nxt = bus.ud ? 7'b1000001 : 7'b0100001;
            default: seg_nxt = 7'b1111111;
        endcase
    end

    // Registered drive: an/seg follow the digit index one clk later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
        end else begin
            an_q  <= bus.en ? ~(4'b0001 << idx) : 4'b1111;
            seg_q <= seg_nxt;
        end
    end

    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.dp   = 1'b1;
    assign bus.busy = busy;
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed + randomized bench for seg7_scan_driver; reference derives digits with /100, /10, %10.
module tb_seg7_scan_driver;

    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    logic        en_s;
    logic        ud_s;
    logic [11:0] exp_bcd;
    int          cur_v;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    // Clock edges since reset release, and inputs as seen at each edge.
    always @(posedge clk or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    always @(posedge clk) begin
        en_s <= bus.en;
        ud_s <= bus.ud;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int idx, input int v, input logic u);
        int h;
        int t;
        int o;
        bit show_h;
        bit show_t;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        show_h = 1'b1;
        show_t = 1'b1;
`ifdef SEG7_LZ_BLANK_EN
        show_h = (h != 0);
        show_t = (h != 0) || (t != 0);
`endif
        case (idx)
            0:       return seg_tab[o];
            1:       return show_t ? seg_tab[t] : 7'b1111111;
            2:       return show_h ? seg_tab[h] : 7'b1111111;
            default: return u ? 7'b1000001 : 7'b0100001;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_scan(input string tag, input int v);
        int idx;
        logic [3:0] an_exp;
        idx = ((edge_cnt - 1) / SCAN_DIV) % 4;
        an_exp = 4'b1111;
        if (en_s) an_exp[idx] = 1'b0;
        check({tag, "_an"},  bus.an,  an_exp);
        check({tag, "_seg"}, bus.seg, exp_seg(idx, v, ud_s));
    endtask

    // Expects the next edge to be E0 of a conversion of v.
    task automatic measure(input int v, input string tag);
        int n;
        tick();
        check({tag, "_e0_busy"}, bus.busy, 1);
        n = 1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (!bus.busy) break;
            n++;
            check({tag, "_hold"}, bus.bcd, exp_bcd);
        end
        check({tag, "_len"}, n, 10);
        check({tag, "_bcd"}, bus.bcd, to_bcd(v));
        exp_bcd = to_bcd(v);
        cur_v   = v;
    endtask

    initial begin
        int v;
        reset     = 1'b1;
        bus.value = 8'd0;
        bus.ud    = 1'b1;
        bus.en    = 1'b1;
        exp_bcd   = 12'h000;
        cur_v     = 0;

        // Reset state.
        #2;
        check("rst_an",   bus.an,   4'b1111);
        check("rst_seg",  bus.seg,  7'b1111111);
        check("rst_busy", bus.busy, 0);
        check("rst_bcd",  bus.bcd,  12'h000);
        check("rst_dp",   bus.dp,   1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Forced first conversion of 0, then step to 255.
        measure(0, "first");
        bus.value = 8'd255;
        measure(255, "max");

        // Scan order with value 7, starting from a fresh reset.
        reset = 1'b1;
        bus.value = 8'd7;
        bus.ud = 1'b1;
        bus.en = 1'b1;
        tick();
        reset = 1'b0;
        exp_bcd = 12'h000;
        measure(7, "scan_conv");
        repeat (32) begin
            tick();
            check_scan("scan", 7);
        end

        // Blanking while the scan keeps running, then resume and glyph flip.
        bus.en = 1'b0;
        repeat (10) begin
            tick();
            check_scan("dis", 7);
        end
        bus.en = 1'b1;
        repeat (8) begin
            tick();
            check_scan("reen", 7);
        end
        bus.ud = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_scan("ud_scan", 7);
            if (((edge_cnt - 1) / SCAN_DIV) % 4 == 3) begin
                check("glyph_d", bus.seg, 7'b0100001);
                break;
            end
        end

        // Value change during the 3rd SHIFT is deferred to a second conversion.
        bus.value = 8'd100;
        tick();
        check("mid_e0_busy", bus.busy, 1);
        repeat (3) tick();
        bus.value = 8'd200;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!bus.busy) break;
            check("mid_hold", bus.bcd, exp_bcd);
        end
        check("mid_first", bus.bcd, 12'h100);
        exp_bcd = 12'h100;
        measure(200, "mid_second");

        // Randomized values, direction and enable.
        for (int k = 0; k < 12; k++) begin
            v = int'($urandom_range(0, 255));
            if (v == cur_v) v = (v + 1) % 256;
            bus.value = 8'(v);
            measure(v, "rnd");
            bus.ud = 1'($urandom_range(0, 1));
            bus.en = 1'($urandom_range(0, 1));
            repeat (6) begin
                tick();
                check_scan("rnd_scan", v);
            end
        end
        bus.en = 1'b1;

        // Reset in the middle of SHIFT, then a fresh conversion.
        v = (cur_v == 123) ? 124 : 123;
        bus.value = 8'(v);
        tick();
        check("rmid_e0_busy", bus.busy, 1);
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        check("rmid_busy", bus.busy, 0);
        check("rmid_bcd",  bus.bcd,  12'h000);
        check("rmid_an",   bus.an,   4'b1111);
        check("rmid_seg",  bus.seg,  7'b1111111);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_bcd = 12'h000;
        measure(v, "rmid_conv");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
